adder_feeder: RTL and testbench
===============================

ADDER_FEEDER -- requirements
Module: adder_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of operands and results.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports a_empty input 1, a_dout input DATA_WIDTH, a_rd_en output 1: first-word-fall-through operand-A FIFO read side (a_dout valid while a_empty=0; a_rd_en pops).
REQ-005 SHALL have ports b_empty input 1, b_dout input DATA_WIDTH, b_rd_en output 1: same for operand-B FIFO.
REQ-006 SHALL have ports op_valid output 1, op_a output DATA_WIDTH, op_b output DATA_WIDTH: operand issue to the adder (op_valid drives its data-available input).
REQ-007 SHALL have ports res_complete input 1, res_sum input DATA_WIDTH, res_rd_en output 1: adder result side; res_rd_en acknowledges and releases the held result.
REQ-008 SHALL have ports out_full input 1, out_din output DATA_WIDTH, out_wr_en output 1: result FIFO write side.
REQ-009 SHALL have ports busy output 1 (state not IDLE) and result_count output 16 (results written since reset).

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT.
REQ-011 IDLE: when a_empty=0 and b_empty=0, SHALL assert a_rd_en and b_rd_en together for one cycle, register a_dout/b_dout into op_a/op_b, go to ISSUE.
REQ-012 IDLE: if either FIFO empty, SHALL pop neither and stay in IDLE.
REQ-013 ISSUE: SHALL assert op_valid for exactly one cycle, then go to WAIT.
REQ-014 op_a/op_b SHALL remain stable from ISSUE until the result is acknowledged.
REQ-015 WAIT: when res_complete=1 and out_full=0, SHALL in the same cycle assert out_wr_en=1, res_rd_en=1, out_din=res_sum, increment result_count, go to IDLE.
REQ-016 WAIT: when res_complete=1 and out_full=1, SHALL hold with out_wr_en=0, res_rd_en=0 until out_full=0; result never dropped or duplicated.
REQ-017 res_complete SHALL be ignored in IDLE and ISSUE.
REQ-018 out_wr_en, res_rd_en, op_valid, a_rd_en, b_rd_en SHALL each be single-cycle pulses, never asserted in two consecutive cycles.
REQ-019 Latency: pop cycle t, op_valid at t+1, earliest out_wr_en at t+2; with a 1-cycle adder steady-state throughput SHALL be one result per 3 cycles.
REQ-020 out_din SHALL be res_sum unmodified (modulo 2^DATA_WIDTH as produced by the adder); no width change.
REQ-021 result_count SHALL saturate at 16'hFFFF, not wrap.
REQ-022 out_din SHALL be driven only with out_wr_en=1 meaningful; value otherwise don't-care but held at last written value.

Reset
REQ-023 reset=0 SHALL asynchronously force state IDLE, op_a=op_b=0, out_din=0, result_count=0, all strobes and busy 0.
REQ-024 reset asserted mid-transaction SHALL abandon the in-flight operands without any write or acknowledge; after release, operation resumes from IDLE on the next non-empty pair.
REQ-025 No FIFO pop SHALL occur in the first cycle after reset deassertion unless both FIFOs are non-empty at that edge.

Verification
REQ-026 Single op: A={5}, B={7}, adder 1-cycle -> one out_wr_en with out_din=12, result_count=1, exactly one a_rd_en, b_rd_en, res_rd_en.
REQ-027 Stream: A={1,2,3,4}, B={10,20,30,40} -> out_din sequence 11,22,33,44, one write every 3 cycles, result_count=4.
REQ-028 Wrap: A=32'hFFFFFFFF, B=1 -> out_din=0, result_count increments.
REQ-029 Backpressure: out_full=1 for 5 cycles while res_complete=1 -> no write/ack during those cycles; single write of correct value on first cycle out_full=0.
REQ-030 Imbalance: A non-empty, B empty for 10 cycles -> no pops, busy=0; B gets 3 -> one pop of each, out_din=A0+3.
REQ-031 Reset mid-op: assert reset in WAIT -> all outputs 0 immediately, no write; after release next pair processed normally, result_count restarts at 1.

Source files
------------

// File: rtl/adder_feeder.sv
// Feeds operand pairs from two FWFT FIFOs into a handshaked adder and pushes
// each sum into a result FIFO. One transaction is in flight at a time.
module adder_feeder #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  a_empty,
    input  logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_rd_en,

    input  logic                  b_empty,
    input  logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_rd_en,

    output logic                  op_valid,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,

    input  logic                  res_complete,
    input  logic [DATA_WIDTH-1:0] res_sum,
    output logic                  res_rd_en,

    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_wr_en,

    output logic                  busy,
    output logic [15:0]           result_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] out_din_q, out_din_d;
    logic [15:0]           count_q, count_d;
    logic                  pop;
    logic                  wr;

    // Reset is folded into the pop term so no strobe can fire while held in reset.
    assign pop = (state_q == IDLE) && !a_empty && !b_empty && reset;
    assign wr  = (state_q == WAIT) && res_complete && !out_full;

    // Next-state and datapath updates for the three-phase transaction.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        out_din_d = out_din_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    op_a_d  = a_dout;
                    op_b_d  = b_dout;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (wr) begin
                    out_din_d = res_sum;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            out_din_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            out_din_q <= out_din_d;
            count_q   <= count_d;
        end
    end

    assign a_rd_en      = pop;
    assign b_rd_en      = pop;
    assign op_valid     = (state_q == ISSUE);
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign res_rd_en    = wr;
    assign out_wr_en    = wr;
    // Sum passes straight through on the write cycle; otherwise the last written value is held.
    assign out_din      = wr ? res_sum : out_din_q;
    assign busy         = (state_q != IDLE);
    assign result_count = count_q;

endmodule

// File: tb/tb_adder_feeder.sv
// Directed bench for adder_feeder with FWFT FIFO models and a 1-cycle adder.
module tb_adder_feeder;

    logic        clock;
    logic        reset;
    logic        a_empty, b_empty, a_rd_en, b_rd_en;
    logic [31:0] a_dout, b_dout;
    logic        op_valid;
    logic [31:0] op_a, op_b;
    logic        res_complete, res_rd_en;
    logic [31:0] res_sum;
    logic        out_full, out_wr_en;
    logic [31:0] out_din;
    logic        busy;
    logic [15:0] result_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] a_mem [0:31];
    logic [31:0] b_mem [0:31];
    int a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0;

    int a_pops = 0, b_pops = 0, res_acks = 0, wr_cnt = 0, viol = 0, cyc = 0;
    logic [31:0] wr_log [0:15];
    int          wr_cyc [0:15];
    logic prev_a = 0, prev_b = 0, prev_v = 0, prev_r = 0, prev_w = 0;

    adder_feeder #(.DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .a_empty(a_empty), .a_dout(a_dout), .a_rd_en(a_rd_en),
        .b_empty(b_empty), .b_dout(b_dout), .b_rd_en(b_rd_en),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
        .res_complete(res_complete), .res_sum(res_sum), .res_rd_en(res_rd_en),
        .out_full(out_full), .out_din(out_din), .out_wr_en(out_wr_en),
        .busy(busy), .result_count(result_count)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    assign a_empty = (a_rd == a_wr);
    assign b_empty = (b_rd == b_wr);
    assign a_dout  = a_mem[a_rd[4:0]];
    assign b_dout  = b_mem[b_rd[4:0]];

    // One-cycle adder holding its result until acknowledged.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_complete <= 1'b0;
            res_sum      <= 32'd0;
        end else if (res_rd_en) begin
            res_complete <= 1'b0;
        end else if (op_valid) begin
            res_complete <= 1'b1;
            res_sum      <= op_a + op_b;
        end
    end

    // FIFO pops, event counts, write log and back-to-back strobe detection.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (a_rd_en) begin a_rd <= a_rd + 1; a_pops <= a_pops + 1; end
        if (b_rd_en) begin b_rd <= b_rd + 1; b_pops <= b_pops + 1; end
        if (res_rd_en) res_acks <= res_acks + 1;
        if (out_wr_en) begin
            wr_log[wr_cnt[3:0]] <= out_din;
            wr_cyc[wr_cnt[3:0]] <= cyc;
            wr_cnt <= wr_cnt + 1;
        end
        if ((a_rd_en && prev_a) || (b_rd_en && prev_b) || (op_valid && prev_v) ||
            (res_rd_en && prev_r) || (out_wr_en && prev_w)) viol <= viol + 1;
        prev_a <= a_rd_en; prev_b <= b_rd_en; prev_v <= op_valid;
        prev_r <= res_rd_en; prev_w <= out_wr_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] va, input logic [31:0] vb);
        a_mem[a_wr[4:0]] = va; a_wr = a_wr + 1;
        b_mem[b_wr[4:0]] = vb; b_wr = b_wr + 1;
    endtask

    task automatic push_a(input logic [31:0] va);
        a_mem[a_wr[4:0]] = va; a_wr = a_wr + 1;
    endtask

    task automatic push_b(input logic [31:0] vb);
        b_mem[b_wr[4:0]] = vb; b_wr = b_wr + 1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic wait_writes(input int n, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            if (wr_cnt >= n) break;
            @(negedge clock);
        end
        chk(tag, (wr_cnt >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        reset    = 1'b0;
        out_full = 1'b0;
        cycles(2);
        // Reset state, with both FIFOs already non-empty.
        push(32'd5, 32'd7);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {16'd0, result_count}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_out_din", out_din, 32'd0);
        chk("rst_pop", {31'd0, a_rd_en}, 32'd0);
        cycles(2);
        chk("rst_no_pop_cnt", a_pops, 32'd0);
        reset = 1'b1;

        // Single operation 5 + 7.
        wait_writes(1, 20, "single_timeout");
        cycles(2);
        chk("single_sum", wr_log[0], 32'd12);
        chk("single_count", {16'd0, result_count}, 32'd1);
        chk("single_a_pops", a_pops, 32'd1);
        chk("single_b_pops", b_pops, 32'd1);
        chk("single_acks", res_acks, 32'd1);

        // Back-to-back stream, one write every 3 cycles.
        push(32'd1, 32'd10); push(32'd2, 32'd20); push(32'd3, 32'd30); push(32'd4, 32'd40);
        wait_writes(5, 40, "stream_timeout");
        cycles(2);
        chk("stream_s0", wr_log[1], 32'd11);
        chk("stream_s1", wr_log[2], 32'd22);
        chk("stream_s2", wr_log[3], 32'd33);
        chk("stream_s3", wr_log[4], 32'd44);
        chk("stream_gap1", wr_cyc[2] - wr_cyc[1], 32'd3);
        chk("stream_gap3", wr_cyc[4] - wr_cyc[3], 32'd3);
        chk("stream_count", {16'd0, result_count}, 32'd5);

        // Modular wrap.
        push(32'hFFFF_FFFF, 32'd1);
        wait_writes(6, 20, "wrap_timeout");
        cycles(1);
        chk("wrap_sum", wr_log[5], 32'd0);
        chk("wrap_count", {16'd0, result_count}, 32'd6);

        // Backpressure: result sits ready while the output FIFO is full.
        out_full = 1'b1;
        push(32'd100, 32'd23);
        cycles(9);
        chk("bp_res_ready", {31'd0, res_complete}, 32'd1);
        chk("bp_no_write", wr_cnt, 32'd6);
        chk("bp_no_ack", res_acks, 32'd6);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        out_full = 1'b0;
        #1;
        chk("bp_wr_en", {31'd0, out_wr_en}, 32'd1);
        chk("bp_din", out_din, 32'd123);
        wait_writes(7, 5, "bp_timeout");
        cycles(4);
        chk("bp_single_write", wr_cnt, 32'd7);
        chk("bp_logged", wr_log[6], 32'd123);
        chk("bp_count", {16'd0, result_count}, 32'd7);

        // Imbalance: A waits alone, then B arrives.
        push_a(32'd50);
        cycles(10);
        chk("imb_a_pops", a_pops, 32'd7);
        chk("imb_busy", {31'd0, busy}, 32'd0);
        push_b(32'd3);
        wait_writes(8, 20, "imb_timeout");
        cycles(1);
        chk("imb_sum", wr_log[7], 32'd53);
        chk("imb_b_pops", b_pops, 32'd8);

        // Reset in WAIT abandons the in-flight pair.
        out_full = 1'b1;
        push(32'd8, 32'd9);
        cycles(4);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_wr", {31'd0, out_wr_en}, 32'd0);
        chk("mid_rst_ack", {31'd0, res_rd_en}, 32'd0);
        chk("mid_rst_op_a", op_a, 32'd0);
        chk("mid_rst_count", {16'd0, result_count}, 32'd0);
        out_full = 1'b0;
        cycles(3);
        chk("mid_no_write", wr_cnt, 32'd8);
        chk("mid_no_ack", res_acks, 32'd8);
        reset = 1'b1;
        push(32'd20, 32'd22);
        wait_writes(9, 20, "mid_timeout");
        cycles(1);
        chk("mid_after_sum", wr_log[8], 32'd42);
        chk("mid_after_count", {16'd0, result_count}, 32'd1);
        chk("pulse_violations", viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
